// File: rtl/mac_pkg.sv
// Shared constants, FSM encoding and saturation limits for the MAC result readout path.
package mac_pkg;

    localparam int unsigned ACC_W   = 24;
    localparam int unsigned OUT_W   = 16;
    localparam int unsigned SHIFT_W = 5;
    localparam int unsigned NBYTES  = OUT_W / 8;
    localparam int unsigned IDX_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    // Signed OUT_W range expressed at accumulator width for comparison.
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(64'sd1 <<< (OUT_W - 1)));

    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/mac_shift_sat.sv
// Arithmetic right shift of the accumulator followed by optional signed saturation to OUT_W.
module mac_shift_sat
    import mac_pkg::*;
(
    input  logic [ACC_W-1:0]   acc_in,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic               sat_en,
    output logic [OUT_W-1:0]   result_c,
    output logic               sat_c
);

    logic signed [ACC_W-1:0] shifted;

    // Shift amounts at or beyond ACC_W naturally produce the sign fill.
    always_comb begin
        shifted  = $signed(acc_in) >>> shift_i;
        result_c = shifted[OUT_W-1:0];
        sat_c    = 1'b0;
        if (sat_en && (shifted > SAT_HI)) begin
            result_c = OUT_MAX;
            sat_c    = 1'b1;
        end else if (sat_en && (shifted < SAT_LO)) begin
            result_c = OUT_MIN;
            sat_c    = 1'b1;
        end
    end

endmodule

// File: rtl/mac_result_serializer.sv
// Snapshots the scaled MAC result on a capture strobe and streams it LSB byte first
// over a valid/ready byte channel.
module mac_result_serializer
    import mac_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ACC_W-1:0]   acc_in,
    input  logic               cap_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic               sat_en,
    input  logic               clr_flags,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               sat_flag,
    output logic               drop_flag
);

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   snap_q, snap_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               sat_d, drop_d, valid_d, last_d, busy_d;
    logic [7:0]         data_d;
    logic [OUT_W-1:0]   result_c;
    logic               sat_c;
    logic               hs, last_hs, load;

    mac_shift_sat u_shift_sat (
        .acc_in   (acc_in),
        .shift_i  (shift_i),
        .sat_en   (sat_en),
        .result_c (result_c),
        .sat_c    (sat_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            idx_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            sat_flag  <= 1'b0;
            drop_flag <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            idx_q     <= idx_d;
            out_data  <= data_d;
            out_valid <= valid_d;
            out_last  <= last_d;
            busy      <= busy_d;
            sat_flag  <= sat_d;
            drop_flag <= drop_d;
        end
    end

    // Next-state logic; the snapshot shifts down one byte per non-final transfer.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        sat_d   = sat_flag;
        drop_d  = clr_flags ? 1'b0 : drop_flag;
        load    = 1'b0;
        hs      = out_valid & out_ready;
        last_hs = hs & out_last;

        case (state_q)
            IDLE: begin
                if (cap_i) load = 1'b1;
            end
            SEND: begin
                if (last_hs) begin
                    if (cap_i) load = 1'b1;
                    else       state_d = IDLE;
                end else begin
                    if (hs) begin
                        snap_d = snap_q >> 8;
                        idx_d  = idx_q + IDX_W'(1);
                    end
                    if (cap_i) drop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d = SEND;
            snap_d  = result_c;
            idx_d   = '0;
            sat_d   = sat_c;
        end

        data_d  = snap_d[7:0];
        valid_d = (state_d == SEND);
        busy_d  = (state_d == SEND);
        last_d  = (state_d == SEND) && (idx_d == LAST_IDX);
    end

endmodule

// File: tb/tb_mac_result_serializer.sv
// Scoreboard bench for mac_result_serializer: expected bytes are queued at capture time
// and compared against every transferred byte.
module tb_mac_result_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] acc_in;
    logic        cap_i;
    logic [4:0]  shift_i;
    logic        sat_en;
    logic        clr_flags;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        sat_flag;
    logic        drop_flag;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       sat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    mac_result_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .acc_in    (acc_in),
        .cap_i     (cap_i),
        .shift_i   (shift_i),
        .sat_en    (sat_en),
        .clr_flags (clr_flags),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .sat_flag  (sat_flag),
        .drop_flag (drop_flag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Independent reference: 64-bit signed shift then clamp to signed 16 bits.
    task automatic push_result(input logic [23:0] acc, input logic [4:0] sh, input logic se);
        longint     v;
        logic [15:0] r;
        logic       s;
        v = longint'($signed(acc));
        if (sh >= 5'd24) v = acc[23] ? -64'sd1 : 64'sd0;
        else             v = v >>> sh;
        s = 1'b0;
        if (se && v > 32767) begin
            r = 16'h7FFF; s = 1'b1;
        end else if (se && v < -32768) begin
            r = 16'h8000; s = 1'b1;
        end else begin
            r = v[15:0];
        end
        exp_q.push_back('{data: r[7:0],  last: 1'b0, sat: s});
        exp_q.push_back('{data: r[15:8], last: 1'b1, sat: s});
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [23:0] acc, input logic [4:0] sh, input logic se);
        acc_in  = acc;
        shift_i = sh;
        sat_en  = se;
        cap_i   = 1'b1;
        cycle();
        cap_i   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (!busy && exp_q.size() == 0) break;
            cycle();
        end
        check(tag, {30'd0, busy, exp_q.size() != 0}, 32'd0);
    endtask

    // Every transferred byte is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("byte_data", {24'd0, out_data}, {24'd0, e.data});
                check("byte_last", {31'd0, out_last}, {31'd0, e.last});
                check("byte_sat",  {31'd0, sat_flag}, {31'd0, e.sat});
            end
        end
    end

    initial begin
        rst_n = 1'b0; acc_in = '0; cap_i = 1'b0; shift_i = '0; sat_en = 1'b0;
        clr_flags = 1'b0; out_ready = 1'b0;
        repeat (3) cycle();
        check("rst_outputs", {out_data, out_valid, out_last, busy, sat_flag, drop_flag}, 32'd0);
        rst_n = 1'b1;
        cycle();

        // 1: positive saturation, busy drops after second byte
        out_ready = 1'b1;
        push_result(24'h012345, 5'd0, 1'b1);
        cap(24'h012345, 5'd0, 1'b1);
        check("t1_busy_first", {31'd0, busy}, 32'd1);
        check("t1_first_byte", {24'd0, out_data}, 32'hFF);
        cycle();
        cycle();
        check("t1_busy_after", {31'd0, busy}, 32'd0);
        wait_idle("t1_drain");

        // 2: negative in-range shift, then full sign-fill shift
        push_result(24'hFFFF80, 5'd4, 1'b1);
        cap(24'hFFFF80, 5'd4, 1'b1);
        wait_idle("t2a_drain");
        push_result(24'hFFFF80, 5'd31, 1'b1);
        cap(24'hFFFF80, 5'd31, 1'b1);
        wait_idle("t2b_drain");

        // 3: truncation with backpressure
        out_ready = 1'b0;
        push_result(24'h012345, 5'd0, 1'b0);
        cap(24'h012345, 5'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_data",  {24'd0, out_data},  32'h45);
            check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            cycle();
        end
        out_ready = 1'b1;
        wait_idle("t3_drain");
        check("t3_valid_low", {31'd0, out_valid}, 32'd0);

        // 4: refused capture on byte 0, then back-to-back reload on last handshake
        out_ready = 1'b0;
        push_result(24'h012345, 5'd0, 1'b0);
        cap(24'h012345, 5'd0, 1'b0);
        cap(24'h7FFFFF, 5'd0, 1'b1);
        check("t4_drop_set", {31'd0, drop_flag}, 32'd1);
        check("t4_stream_kept", {24'd0, out_data}, 32'h45);
        out_ready = 1'b1;
        cycle();
        check("t4_on_last", {31'd0, out_last}, 32'd1);
        push_result(24'h000102, 5'd0, 1'b0);
        cap(24'h000102, 5'd0, 1'b0);
        check("t4_reload_valid", {31'd0, out_valid}, 32'd1);
        check("t4_reload_data",  {24'd0, out_data},  32'h02);
        wait_idle("t4_drain");

        // 5: clear, then clear colliding with a refused capture
        clr_flags = 1'b1;
        cycle();
        clr_flags = 1'b0;
        check("t5_cleared", {31'd0, drop_flag}, 32'd0);
        out_ready = 1'b0;
        push_result(24'h00ABCD, 5'd2, 1'b0);
        cap(24'h00ABCD, 5'd2, 1'b0);
        clr_flags = 1'b1;
        cap(24'h000000, 5'd0, 1'b0);
        clr_flags = 1'b0;
        check("t5_set_wins", {31'd0, drop_flag}, 32'd1);
        out_ready = 1'b1;
        wait_idle("t5_drain");

        // 6: reset mid-stream abandons the result
        out_ready = 1'b0;
        cap(24'h012345, 5'd0, 1'b1);
        cap(24'h000001, 5'd0, 1'b0);
        rst_n = 1'b0;
        cycle();
        exp_q.delete();
        check("t6_rst_outputs", {out_data, out_valid, out_last, busy, sat_flag, drop_flag}, 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycle();
        check("t6_no_residual", {31'd0, out_valid}, 32'd0);
        push_result(24'h000000, 5'd0, 1'b0);
        cap(24'h000000, 5'd0, 1'b0);
        wait_idle("t6_drain");

        // A few pseudo-random captures through the scoreboard
        for (int i = 0; i < 8; i++) begin
            logic [23:0] a;
            logic [4:0]  s;
            logic        e;
            a = 24'($urandom);
            s = 5'($urandom_range(0, 31));
            e = 1'($urandom);
            push_result(a, s, e);
            cap(a, s, e);
            wait_idle("rand_drain");
        end

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
